// File: rtl/gray_code_display_top.sv
// ============================================================================
// gray_code_display_top
// ----------------------------------------------------------------------------
// Board-level code converter for Nexys-class boards.
//
// A WIDTH-bit code is sampled from the slide switches and converted in one of
// four modes selected by SW[15:14]:
//    00 : binary -> Gray
//    01 : Gray   -> binary
//    10 : free-running up counter, Gray-coded output
//    11 : free-running down counter, Gray-coded output
// The result is registered, echoed on the LEDs, and both the result and the
// source value are shown as hex on the 8-digit multiplexed 7-segment display.
//
// Data path is two register stages deep. Stage 1 captures the mode and code
// (in_q / mode_q). Stage 2 computes res_q. A switch change therefore reaches
// the LEDs two clocks later.
//
// Parameters
//    WIDTH     code width in bits, 1..12
//    SCAN_DIV  clocks per display digit slot, >= 2
//    STEP_DIV  clocks per counter step in the counter modes, >= 2
//
// Ports
//    CLK100MHZ  in   system clock, rising edge
//    RST        in   synchronous reset, active high
//    SW[15:0]   in   [WIDTH-1:0] code, [13] HOLD, [15:14] MODE
//    LED[15:0]  out  [WIDTH-1:0] result, [13] HOLD echo, [15:14] MODE echo
//    AN[7:0]    out  digit enables, active low, AN[0] = rightmost digit
//    A2G[6:0]   out  segments a..g, active low, A2G[6] = a
//
// Display layout
//    Digits 0..3 show nibbles 0..3 of the result, digits 4..7 show nibbles
//    0..3 of the source value (in_q, or the counter in counter modes).
//    Nibbles at or above ceil(WIDTH/4) are always dark.
//
// Build option
//    LEADING_ZERO_BLANK_EN : when defined, leading zero nibbles of each half
//    are blanked as well (nibble 0 stays lit so a zero value shows one '0').
//    When undefined, every existing nibble is shown, leading zeros included.
// ============================================================================
module gray_code_display_top #(
   parameter int WIDTH    = 8,
   parameter int SCAN_DIV = 100000,
   parameter int STEP_DIV = 50000000
) (
   input  logic        CLK100MHZ,
   input  logic        RST,
   input  logic [15:0] SW,
   output logic [15:0] LED,
   output logic [7:0]  AN,
   output logic [6:0]  A2G
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   localparam int NH     = (WIDTH + 3) / 4;           // hex digits per half
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int STEP_W = $clog2(STEP_DIV);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [1:0]        TOP_FULL  = 2'(NH - 1);

   // -------------------------------------------------------------------------
   // Switch field decode
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] sw_code;
   logic             sw_hold;
   logic [1:0]       sw_mode;

   assign sw_code = SW[WIDTH-1:0];
   assign sw_hold = SW[13];
   assign sw_mode = SW[15:14];

   // Bits between the code field and HOLD carry no function.
   logic unused_sw;
   assign unused_sw = &{1'b0, SW};

   // -------------------------------------------------------------------------
   // Registered state
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0]  in_q;
   logic [1:0]        mode_q;
   logic              hold_reg;
   logic [WIDTH-1:0]  cnt;
   logic [STEP_W-1:0] step_pre_reg;
   logic [WIDTH-1:0]  res_q;
   logic [SCAN_W-1:0] scan_pre_reg;
   logic [2:0]        idx_reg;
   logic [7:0]        an_reg;
   logic [6:0]        a2g_reg;

   // -------------------------------------------------------------------------
   // Stage 1 control
   // -------------------------------------------------------------------------
   // Entering a counter mode is detected on the same edge that moves mode_q
   // into 10/11, so the counter already holds the seed value on the first
   // cycle the data path reads it. Hopping directly between 10 and 11 is not
   // an entry and keeps both count and prescaler phase.
   logic enter_count;
   logic step_run;
   logic step_fire;

   assign enter_count = sw_mode[1] & ~mode_q[1];
   assign step_run    = mode_q[1] & ~sw_hold;
   assign step_fire   = step_run & (step_pre_reg == STEP_LAST);

   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         in_q         <= '0;
         mode_q       <= 2'b00;
         hold_reg     <= 1'b0;
         cnt          <= '0;
         step_pre_reg <= '0;
      end else begin
         mode_q   <= sw_mode;
         hold_reg <= sw_hold;

         if (!sw_hold) begin
            in_q <= sw_code;
         end

         if (enter_count) begin
            cnt          <= in_q;
            step_pre_reg <= '0;
         end else if (step_fire) begin
            step_pre_reg <= '0;
            cnt          <= mode_q[0] ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
         end else if (step_run) begin
            step_pre_reg <= step_pre_reg + STEP_W'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stage 2 conversion
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] src_gray;
   logic [WIDTH-1:0] src_bin;
   logic [WIDTH-1:0] res_next;

   assign src      = mode_q[1] ? cnt : in_q;
   assign src_gray = src ^ (src >> 1);

   // Gray -> binary: each output bit is the parity of all code bits at and
   // above it. Written as independent reductions to keep the cone flat.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_g2b
         assign src_bin[gi] = ^src[WIDTH-1:gi];
      end
   endgenerate

   always_comb begin
      res_next = src_gray;
      if (mode_q == 2'b01) begin
         res_next = src_bin;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         res_q <= '0;
      end else begin
         res_q <= res_next;
      end
   end

   // -------------------------------------------------------------------------
   // LED echo
   // -------------------------------------------------------------------------
   logic [15:0] led_next;

   always_comb begin
      led_next              = '0;
      led_next[WIDTH-1:0]   = res_q;
      led_next[13]          = hold_reg;
      led_next[15:14]       = mode_q;
   end

   assign LED = led_next;

   // -------------------------------------------------------------------------
   // Display nibble extraction
   // -------------------------------------------------------------------------
   // Both halves are zero-extended to four nibbles; nibbles beyond the code
   // width read as zero and are blanked by the lit test below.
   logic [15:0] res_ext;
   logic [15:0] src_ext;
   logic [3:0]  res_nib [4];
   logic [3:0]  src_nib [4];

   assign res_ext = 16'(res_q);
   assign src_ext = 16'(src);

   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign res_nib[gi] = res_ext[4*gi +: 4];
         assign src_nib[gi] = src_ext[4*gi +: 4];
      end
   endgenerate

   // Highest nibble index that is lit in each half.
   logic [1:0] res_top;
   logic [1:0] src_top;

`ifdef LEADING_ZERO_BLANK_EN
   function automatic logic [1:0] top_nibble(input logic [15:0] v);
      logic [1:0] t;
      t = 2'd0;
      for (int n = 1; n < 4; n++) begin
         if (v[4*n +: 4] != 4'h0) begin
            t = 2'(n);
         end
      end
      return t;
   endfunction

   assign res_top = top_nibble(res_ext);
   assign src_top = top_nibble(src_ext);
`else
   assign res_top = TOP_FULL;
   assign src_top = TOP_FULL;
`endif

   // -------------------------------------------------------------------------
   // Hex to 7-segment, active low, {a,b,c,d,e,f,g}
   // -------------------------------------------------------------------------
   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // -------------------------------------------------------------------------
   // Scan timing
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         scan_pre_reg <= '0;
         idx_reg      <= 3'd0;
      end else if (scan_pre_reg == SCAN_LAST) begin
         scan_pre_reg <= '0;
         idx_reg      <= idx_reg + 3'd1;
      end else begin
         scan_pre_reg <= scan_pre_reg + SCAN_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Digit select and output registers
   // -------------------------------------------------------------------------
   // Enable and pattern are derived from the same idx value and latched on the
   // same edge, so a newly selected digit never shows the previous pattern.
   logic [1:0] slot_nib;
   logic       slot_src;
   logic [3:0] slot_digit;
   logic [1:0] slot_top;
   logic       slot_lit;
   logic [7:0] an_next;
   logic [6:0] a2g_next;

   always_comb begin
      slot_nib   = idx_reg[1:0];
      slot_src   = idx_reg[2];
      slot_digit = slot_src ? src_nib[slot_nib] : res_nib[slot_nib];
      slot_top   = slot_src ? src_top : res_top;
      slot_lit   = (slot_nib <= slot_top);
      an_next    = 8'hFF;
      a2g_next   = 7'h7F;
      if (slot_lit) begin
         an_next  = ~(8'b1 << idx_reg);
         a2g_next = hex7(slot_digit);
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         an_reg  <= 8'hFF;
         a2g_reg <= 7'h7F;
      end else begin
         an_reg  <= an_next;
         a2g_reg <= a2g_next;
      end
   end

   assign AN  = an_reg;
   assign A2G = a2g_reg;

endmodule

// File: tb/tb_gray_code_display_top.sv
// ============================================================================
// tb_gray_code_display_top
// Self-checking bench for gray_code_display_top with WIDTH=8, SCAN_DIV=4,
// STEP_DIV=8. Expected values come from arithmetic models below.
// ============================================================================
module tb_gray_code_display_top;

   localparam int WIDTH    = 8;
   localparam int SCAN_DIV = 4;
   localparam int STEP_DIV = 8;
   localparam int NH       = (WIDTH + 3) / 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic [15:0] led;
   logic [7:0]  an;
   logic [6:0]  a2g;

   int n_pass  = 0;
   int n_total = 0;
   int nsr     = 0;   // clock edges since reset was released

   gray_code_display_top #(
      .WIDTH    (WIDTH),
      .SCAN_DIV (SCAN_DIV),
      .STEP_DIV (STEP_DIV)
   ) dut (
      .CLK100MHZ (clk),
      .RST       (rst),
      .SW        (sw),
      .LED       (led),
      .AN        (an),
      .A2G       (a2g)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) nsr <= 0;
      else     nsr <= nsr + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_gray(input int v);
      int x;
      x = v & 255;
      return 8'(x ^ (x >> 1));
   endfunction

   // Inverse Gray by search: the binary value whose Gray code matches.
   function automatic logic [7:0] m_bin(input logic [7:0] g);
      for (int b = 0; b < 256; b++) begin
         if (m_gray(b) == g) return 8'(b);
      end
      return 8'h00;
   endfunction

   function automatic logic [6:0] m_seg(input int d);
      case (d)
         0:  return 7'b0000001;
         1:  return 7'b1001111;
         2:  return 7'b0010010;
         3:  return 7'b0000110;
         4:  return 7'b1001100;
         5:  return 7'b0100100;
         6:  return 7'b0100000;
         7:  return 7'b0001111;
         8:  return 7'b0000000;
         9:  return 7'b0000100;
         10: return 7'b0001000;
         11: return 7'b1100000;
         12: return 7'b0110001;
         13: return 7'b1000010;
         14: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   function automatic int m_top(input int v);
      int t;
      t = 0;
      for (int k = 1; k < 4; k++) begin
         if (((v / (16 ** k)) % 16) != 0) t = k;
      end
      return t;
   endfunction
`endif

   // Digit shown after the current edge: the output register lags idx by one.
   function automatic int m_slot();
      return ((nsr - 1) / SCAN_DIV) % 8;
   endfunction

   task automatic check_display(input int r, input int s, input int cycles, input string tag);
      int slot, nib, v, d;
      bit lit;
      logic [7:0] exp_an;
      for (int i = 0; i < cycles; i++) begin
         tick();
         slot = m_slot();
         nib  = slot % 4;
         v    = (slot < 4) ? r : s;
         d    = (v / (16 ** nib)) % 16;
         lit  = (nib < NH);
`ifdef LEADING_ZERO_BLANK_EN
         if (nib > m_top(v)) lit = 1'b0;
`endif
         exp_an = lit ? ~8'(1 << slot) : 8'hFF;
         n_total++;
         if (an !== exp_an) $display("FAIL %s_an slot %0d: got %h expected %h", tag, slot, an, exp_an);
         else n_pass++;
         if (lit) begin
            n_total++;
            if (a2g !== m_seg(d)) $display("FAIL %s_a2g slot %0d: got %b expected %b", tag, slot, a2g, m_seg(d));
            else n_pass++;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit found;
      rst = 1'b1;
      sw  = 16'hFFFF;
      repeat (3) tick();
      n_total++; if (led !== 16'h0000) $display("FAIL reset_led: got %h expected 0000", led); else n_pass++;
      n_total++; if (an !== 8'hFF)     $display("FAIL reset_an: got %h expected ff", an); else n_pass++;
      n_total++; if (a2g !== 7'h7F)    $display("FAIL reset_a2g: got %h expected 7f", a2g); else n_pass++;
      sw    = 16'h0000;
      rst   = 1'b0;
      found = 1'b0;
      for (int i = 0; i < SCAN_DIV + 1 && !found; i++) begin
         tick();
         if (an !== 8'hFF) found = 1'b1;
      end
      n_total++;
      if (!found || an !== 8'hFE) $display("FAIL first_slot: got %h expected fe within %0d clocks", an, SCAN_DIV + 1);
      else n_pass++;
      $display("reset: led=%h an=%h", led, an);
   endtask

   task automatic test_bin_to_gray();
      sw = 16'h00B7;
      tick();
      n_total++; if (led !== 16'h0000) $display("FAIL b2g_latency1: got %h expected 0000", led); else n_pass++;
      tick();
      n_total++; if (led !== {8'h00, m_gray(8'hB7)}) $display("FAIL b2g_led: got %h expected %h", led, {8'h00, m_gray(8'hB7)}); else n_pass++;
      $display("b2g: sw=%h led=%h", sw, led);
      check_display(int'(m_gray(8'hB7)), 8'hB7, 32, "b2g_disp");
   endtask

   task automatic test_gray_to_bin();
      logic [15:0] exp;
      sw = 16'h40EC;
      tick(); tick();
      exp = {8'h40, m_bin(8'hEC)};
      n_total++; if (led !== exp) $display("FAIL g2b_led: got %h expected %h", led, exp); else n_pass++;
      $display("g2b: sw=%h led=%h", sw, led);
      sw = 16'h6000;
      repeat (3) tick();
      exp = {8'h60, m_bin(8'hEC)};
      n_total++; if (led !== exp) $display("FAIL g2b_hold: got %h expected %h", led, exp); else n_pass++;
      $display("g2b hold: sw=%h led=%h", sw, led);
      check_display(int'(m_bin(8'hEC)), 8'hEC, 16, "hold_disp");
   endtask

   task automatic test_count_up();
      logic [15:0] exp;
      sw = 16'h00FE;
      tick(); tick();
      sw = 16'h80FE;
      tick();                       // mode enters counter, counter seeded
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 8 || k == 9 || k == 16 || k == 17) begin
            exp = {8'h80, m_gray(8'hFE + (k - 1) / STEP_DIV)};
            n_total++;
            if (led !== exp) $display("FAIL count_up_k%0d: got %h expected %h", k, led, exp);
            else n_pass++;
            $display("count up: clk %0d led=%h", k, led);
         end
      end
   endtask

   task automatic test_count_down_switch();
      logic [15:0] exp;
      sw = 16'h0000;
      tick(); tick();
      sw = 16'hC000;
      tick();
      for (int k = 1; k <= 17; k++) begin
         tick();
         exp = 16'hFFFF;
         case (k)
            8:  exp = {8'hC0, m_gray(0)};
            9:  exp = {8'hC0, m_gray(255)};
            13: exp = {8'h80, m_gray(255)};
            16: exp = {8'h80, m_gray(255)};
            17: exp = {8'h80, m_gray(0)};
            default: ;
         endcase
         if (exp !== 16'hFFFF) begin
            n_total++;
            if (led !== exp) $display("FAIL count_dn_k%0d: got %h expected %h", k, led, exp);
            else n_pass++;
            $display("count down/up: clk %0d led=%h", k, led);
         end
         if (k == 11) sw = 16'h8000;   // switch direction mid-prescale
      end
   endtask

   task automatic test_random_convert();
      int v, junk, m;
      logic [15:0] exp;
      for (int i = 0; i < 20; i++) begin
         v    = int'($urandom_range(0, 255));
         junk = int'($urandom_range(0, 31));
         m    = int'($urandom_range(0, 1));
         sw   = {1'b0, m[0], 1'b0, junk[4:0], v[7:0]};
         tick(); tick();
         exp = {1'b0, m[0], 6'b0, (m == 1) ? m_bin(v[7:0]) : m_gray(v)};
         n_total++;
         if (led !== exp) $display("FAIL rand_conv_%0d: got %h expected %h", i, led, exp);
         else n_pass++;
         $display("rand conv: sw=%h led=%h", sw, led);
      end
   endtask

   task automatic test_random_count();
      int start, dir, k, val;
      logic [15:0] exp;
      for (int i = 0; i < 4; i++) begin
         start = int'($urandom_range(0, 255));
         dir   = int'($urandom_range(0, 1));
         k     = int'($urandom_range(1, 3));
         sw    = {8'h00, start[7:0]};
         tick(); tick();
         sw = {1'b1, dir[0], 6'b0, start[7:0]};
         tick();
         repeat (STEP_DIV * k + 1) tick();
         val = (dir == 1) ? (start - k + 256) % 256 : (start + k) % 256;
         exp = {1'b1, dir[0], 6'b0, m_gray(val)};
         n_total++;
         if (led !== exp) $display("FAIL rand_cnt_%0d: got %h expected %h", i, led, exp);
         else n_pass++;
         $display("rand count: start=%h dir=%0d steps=%0d led=%h", start, dir, k, led);
      end
   endtask

   task automatic test_scan_wrap_reset();
      bit found;
      sw = 16'h00B7;
      tick(); tick();
      check_display(int'(m_gray(8'hB7)), 8'hB7, 36, "wrap_disp");
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (m_slot() == 5) found = 1'b1;
      end
      n_total++;
      if (!found) $display("FAIL wait_slot5: got no slot 5 expected within 40 clocks");
      else n_pass++;
      rst = 1'b1;
      tick();
      n_total++; if (an !== 8'hFF)  $display("FAIL midscan_rst_an: got %h expected ff", an); else n_pass++;
      n_total++; if (a2g !== 7'h7F) $display("FAIL midscan_rst_a2g: got %h expected 7f", a2g); else n_pass++;
      rst = 1'b0;
      tick();
      n_total++; if (an !== 8'hFE) $display("FAIL restart_slot0: got %h expected fe", an); else n_pass++;
      repeat (SCAN_DIV) tick();
      n_total++; if (an !== 8'hFD) $display("FAIL restart_slot1: got %h expected fd", an); else n_pass++;
      $display("scan reset: an=%h", an);
   endtask

   initial begin
      rst = 1'b1;
      sw  = 16'hFFFF;
      test_reset();
      test_bin_to_gray();
      test_gray_to_bin();
      test_count_up();
      test_count_down_switch();
      test_random_convert();
      test_random_count();
      test_scan_wrap_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
